game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
Top-level game-flow controller for BrickBreaker. It sequences screen clear, level load, serve delay, play, and win/lose banners. It owns the brick-health and lives bookkeeping and gates the ball/paddle datapath through play_enable. It sits between the VGA clear/level-load engines and the collision logic, which reports brick_hit and ball_lost pulses.

Parameters:
LIVES, 3, lives granted on start (1..3, fits 2 bits)
HEALTH_W, 10, width of health counters
LEVEL_W, 3, width of level index
SERVE_FRAMES, 60, frame_tick count spent in SERVE before PLAY
HOLD_FRAMES, 120, frame_tick count spent in WIN/LOSE banner

Ports:
clk  input  1  system clock
resetn  input  1  reset; asynchronous, active-low
start  input  1  one-cycle pulse from player button (debounced upstream)
frame_tick  input  1  one-cycle pulse per video frame
clear_done  input  1  one-cycle pulse: screen clear finished
load_done  input  1  one-cycle pulse: brick field drawn
total_health  input  HEALTH_W  sum of brick health for current level, valid while load_level high
brick_hit  input  1  one-cycle pulse, one per health point removed
ball_lost  input  1  one-cycle pulse, ball passed paddle
clear_start  output  1  one-cycle pulse requesting screen clear
load_level  output  1  level held high while in LOAD
level  output  LEVEL_W  current level index
play_enable  output  1  high only in PLAY
health_remaining  output  HEALTH_W  bricks' remaining health
lives  output  2  lives remaining
win  output  1  high while in WIN
lose  output  1  high while in LOSE
state  output  3  current state code (debug/HEX display)

Behaviour:
- Async reset: state=IDLE, all pulses/levels 0, health_remaining=0, lives=LIVES, level=0, frame counter 0. Reset mid-operation aborts immediately; in-flight done pulses are ignored.
- All outputs registered (Moore). clear_start is high for exactly the one cycle after entering CLEAR.
- IDLE: start -> CLEAR; lives<=LIVES, level<=0. start is ignored in all other states.
- CLEAR: pulse clear_start; wait for clear_done -> LOAD. clear_done outside CLEAR is ignored.
- LOAD: load_level=1; on load_done, latch health_remaining<=total_health. If total_health==0 -> WIN, else -> SERVE.
- SERVE: count frame_tick; when SERVE_FRAMES ticks are reached -> PLAY, counter cleared.
- PLAY: play_enable=1.
  - brick_hit decrements health_remaining. Decrement from 1 -> 0 moves to WIN next cycle. Saturate at 0 (no wrap).
  - ball_lost with lives>1: lives-=1 -> SERVE. With lives==1: lives<=0 -> LOSE.
  - Simultaneous hit and lost: the hit is applied first. If the hit empties health -> WIN and lives are unchanged; otherwise the loss is processed normally.
  - brick_hit/ball_lost outside PLAY are ignored.
- WIN: win=1; after HOLD_FRAMES ticks, level<=level+1 (wraps modulo 2^LEVEL_W) -> CLEAR. Lives are kept.
- LOSE: lose=1; after HOLD_FRAMES ticks -> IDLE. Lives and level are held for display until the next start.
- Frame counter is cleared on every state entry. Width is clog2(max(SERVE_FRAMES,HOLD_FRAMES)+1).
- State codes: IDLE 0, CLEAR 1, LOAD 2, SERVE 3, PLAY 4, WIN 5, LOSE 6; code 7 is illegal -> IDLE.

Decomposition:
- game_pkg: state code localparams, LIVES/HOLD defaults.
- Sub-module frame_timer: takes clear, frame_tick, target; produces a done pulse when the count equals target. Instantiated once and shared by SERVE/WIN/LOSE via target mux.

Test Plan:
1. Reset, start, clear_done, load_done with total_health=3, then 60 frame_ticks -> play_enable rises on the cycle after the 60th tick; health_remaining=3, lives=3.
2. In PLAY, issue 3 brick_hit pulses -> health_remaining 2,1,0; win=1 one cycle after the third hit. After 120 ticks, level=1 and clear_start pulses once.
3. In PLAY with lives=3, issue 3 ball_lost with serves between -> lives 2 (SERVE), 1 (SERVE), 0 (LOSE, lose=1). After 120 ticks -> IDLE, start reinitialises lives=3, level=0.
4. health_remaining=1, lives=1, brick_hit and ball_lost in the same cycle -> WIN, lives stays 1, lose never asserts.
5. load_done with total_health=0 -> WIN directly, SERVE skipped. Separately, brick_hit while in SERVE -> health_remaining unchanged.
6. Assert resetn low mid-PLAY (asynchronously, between clk edges) -> outputs at reset values before the next clk edge; clear_done arriving later in IDLE -> no state change.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the BrickBreaker game-flow controller:
// state codes, parameter defaults and a small elaboration helper.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SERVE = 3'd3,
    ST_PLAY  = 3'd4,
    ST_WIN   = 3'd5,
    ST_LOSE  = 3'd6
  } gameState_t;

  localparam int DefaultLives       = 3;
  localparam int DefaultHealthW     = 10;
  localparam int DefaultLevelW      = 3;
  localparam int DefaultServeFrames = 60;
  localparam int DefaultHoldFrames  = 120;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_sequencer_frame_timer.sv
// Frame-tick counter shared by the timed states. o_done fires on the tick
// that brings the count up to i_target, so the owner can leave on that edge.
module frame_timer
  import game_pkg::*;
#(
  parameter int COUNT_W = 7
) (
  input  logic               i_clk,
  input  logic               i_resetn,
  input  logic               i_clear,
  input  logic               i_frame_tick,
  input  logic [COUNT_W-1:0] i_target,
  output logic               o_done
);

  logic [COUNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_frame_tick) begin
      r_count <= r_count + COUNT_W'(1);
    end
  end

  assign o_done = i_frame_tick && (r_count == (i_target - COUNT_W'(1)));

endmodule

// File: rtl/game_sequencer.sv
// BrickBreaker game-flow controller: sequences clear/load/serve/play and the
// win/lose banners, and owns the brick-health, lives and level bookkeeping.
module game_sequencer
  import game_pkg::*;
#(
  parameter int LIVES        = DefaultLives,
  parameter int HEALTH_W     = DefaultHealthW,
  parameter int LEVEL_W      = DefaultLevelW,
  parameter int SERVE_FRAMES = DefaultServeFrames,
  parameter int HOLD_FRAMES  = DefaultHoldFrames
) (
  input  logic                i_clk,
  input  logic                i_resetn,
  input  logic                i_start,
  input  logic                i_frame_tick,
  input  logic                i_clear_done,
  input  logic                i_load_done,
  input  logic [HEALTH_W-1:0] i_total_health,
  input  logic                i_brick_hit,
  input  logic                i_ball_lost,
  output logic                o_clear_start,
  output logic                o_load_level,
  output logic [LEVEL_W-1:0]  o_level,
  output logic                o_play_enable,
  output logic [HEALTH_W-1:0] o_health_remaining,
  output logic [1:0]          o_lives,
  output logic                o_win,
  output logic                o_lose,
  output logic [2:0]          o_state
);

  localparam int CountW = $clog2(maxInt(SERVE_FRAMES, HOLD_FRAMES) + 1);

  gameState_t          r_state;
  gameState_t          w_nextState;
  logic                w_timerDone;
  logic                w_stateChange;
  logic                w_hitEmpties;
  logic [CountW-1:0]   w_target;

  logic [HEALTH_W-1:0] r_health;
  logic [1:0]          r_lives;
  logic [LEVEL_W-1:0]  r_level;
  logic                r_clearStart;
  logic                r_loadLevel;
  logic                r_playEnable;
  logic                r_win;
  logic                r_lose;

  assign w_hitEmpties  = i_brick_hit && (r_health == HEALTH_W'(1));
  assign w_stateChange = (w_nextState != r_state);
  assign w_target      = (r_state == ST_SERVE) ? CountW'(SERVE_FRAMES) : CountW'(HOLD_FRAMES);

  frame_timer #(
    .COUNT_W (CountW)
  ) u_frameTimer (
    .i_clk        (i_clk),
    .i_resetn     (i_resetn),
    .i_clear      (w_stateChange),
    .i_frame_tick (i_frame_tick),
    .i_target     (w_target),
    .o_done       (w_timerDone)
  );

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A hit that empties the field wins outright, so it outranks a lost ball.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_nextState = ST_CLEAR;
      ST_CLEAR: if (i_clear_done) w_nextState = ST_LOAD;
      ST_LOAD: begin
        if (i_load_done) begin
          w_nextState = (i_total_health == '0) ? ST_WIN : ST_SERVE;
        end
      end
      ST_SERVE: if (w_timerDone) w_nextState = ST_PLAY;
      ST_PLAY: begin
        if (w_hitEmpties) begin
          w_nextState = ST_WIN;
        end else if (i_ball_lost) begin
          w_nextState = (r_lives > 2'd1) ? ST_SERVE : ST_LOSE;
        end
      end
      ST_WIN:   if (w_timerDone) w_nextState = ST_CLEAR;
      ST_LOSE:  if (w_timerDone) w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_health     <= '0;
      r_lives      <= 2'(LIVES);
      r_level      <= '0;
      r_clearStart <= 1'b0;
      r_loadLevel  <= 1'b0;
      r_playEnable <= 1'b0;
      r_win        <= 1'b0;
      r_lose       <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && i_start) begin
        r_lives <= 2'(LIVES);
        r_level <= '0;
      end
      if ((r_state == ST_LOAD) && i_load_done) begin
        r_health <= i_total_health;
      end
      if (r_state == ST_PLAY) begin
        if (i_brick_hit && (r_health != '0)) begin
          r_health <= r_health - HEALTH_W'(1);
        end
        if (i_ball_lost && !w_hitEmpties && (r_lives != 2'd0)) begin
          r_lives <= r_lives - 2'd1;
        end
      end
      if ((r_state == ST_WIN) && w_timerDone) begin
        r_level <= r_level + LEVEL_W'(1);
      end
      r_clearStart <= (w_nextState == ST_CLEAR) && (r_state != ST_CLEAR);
      r_loadLevel  <= (w_nextState == ST_LOAD);
      r_playEnable <= (w_nextState == ST_PLAY);
      r_win        <= (w_nextState == ST_WIN);
      r_lose       <= (w_nextState == ST_LOSE);
    end
  end

  assign o_clear_start      = r_clearStart;
  assign o_load_level       = r_loadLevel;
  assign o_level            = r_level;
  assign o_play_enable      = r_playEnable;
  assign o_health_remaining = r_health;
  assign o_lives            = r_lives;
  assign o_win              = r_win;
  assign o_lose             = r_lose;
  assign o_state            = r_state;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed-random bench for game_sequencer; expected values come from a
// game-level model of health, lives and level kept as plain integers.
module tb_game_sequencer;

  localparam int SIdle = 0, SClear = 1, SLoad = 2, SServe = 3, SPlay = 4, SWin = 5, SLose = 6;
  localparam int ServeFrames = 60;
  localparam int HoldFrames  = 120;
  localparam int StartLives  = 3;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0, frameTick = 1'b0, clearDone = 1'b0, loadDone = 1'b0;
  logic       brickHit = 1'b0, ballLost = 1'b0;
  logic [9:0] totalHealth = '0;

  logic       clearStart, loadLevel, playEnable, win, lose;
  logic [2:0] level;
  logic [9:0] healthRemaining;
  logic [1:0] lives;
  logic [2:0] state;

  int checkCount = 0;
  int passCount  = 0;
  int mHealth, mLives, mLevel, tot, gap;

  game_sequencer dut (
    .i_clk              (clk),
    .i_resetn           (resetn),
    .i_start            (start),
    .i_frame_tick       (frameTick),
    .i_clear_done       (clearDone),
    .i_load_done        (loadDone),
    .i_total_health     (totalHealth),
    .i_brick_hit        (brickHit),
    .i_ball_lost        (ballLost),
    .o_clear_start      (clearStart),
    .o_load_level       (loadLevel),
    .o_level            (level),
    .o_play_enable      (playEnable),
    .o_health_remaining (healthRemaining),
    .o_lives            (lives),
    .o_win              (win),
    .o_lose             (lose),
    .o_state            (state)
  );

  always #5 clk = ~clk;

  // Called at a negedge: holds the pulses for one cycle, returns at the next negedge.
  task automatic applyStimulus(input bit s, input bit cd, input bit ld,
                               input bit hit, input bit lost, input bit tick);
    start = s; clearDone = cd; loadDone = ld; brickHit = hit; ballLost = lost; frameTick = tick;
    @(negedge clk);
    start = 0; clearDone = 0; loadDone = 0; brickHit = 0; ballLost = 0; frameTick = 0;
  endtask

  task automatic ticks(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0, 0, 1);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  task automatic checkModel(input string tag, input int expState);
    checkOutput({tag, ".state"}, 32'(state), 32'(expState));
    checkOutput({tag, ".health"}, 32'(healthRemaining), 32'(mHealth));
    checkOutput({tag, ".lives"}, 32'(lives), 32'(mLives));
    checkOutput({tag, ".level"}, 32'(level), 32'(mLevel));
    checkOutput({tag, ".play"}, 32'(playEnable), 32'(expState == SPlay));
    checkOutput({tag, ".win"}, 32'(win), 32'(expState == SWin));
    checkOutput({tag, ".lose"}, 32'(lose), 32'(expState == SLose));
    checkOutput({tag, ".loadLevel"}, 32'(loadLevel), 32'(expState == SLoad));
  endtask

  task automatic loadAndServe(input int total);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkModel("toLoad", SLoad);
    totalHealth = 10'(total);
    applyStimulus(0, 0, 1, 0, 0, 0);
    mHealth = total;
    checkModel("loaded", (total == 0) ? SWin : SServe);
  endtask

  initial begin
    mHealth = 0; mLives = StartLives; mLevel = 0;
    #12;
    checkModel("reset", SIdle);
    checkOutput("reset.clearStart", 32'(clearStart), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    applyStimulus(1, 0, 0, 0, 0, 0);
    checkModel("start", SClear);
    checkOutput("start.clearStart", 32'(clearStart), 32'd1);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkModel("loadDoneInClear", SClear);
    checkOutput("clearStartOnce", 32'(clearStart), 32'd0);

    tot = $urandom_range(3, 6);
    loadAndServe(tot);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkModel("hitInServe", SServe);
    applyStimulus(1, 0, 0, 0, 1, 0);
    checkModel("startLostInServe", SServe);
    ticks(ServeFrames - 1);
    checkModel("serve59", SServe);
    ticks(1);
    checkModel("serve60", SPlay);

    for (int i = 0; i < tot - 1; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 0, 0);
      mHealth--;
      checkModel("hit", SPlay);
    end
    ticks($urandom_range(1, 10));
    applyStimulus(0, 0, 0, 0, 1, 0);
    mLives--;
    checkModel("lost3to2", SServe);
    ticks(ServeFrames);
    checkModel("reserve", SPlay);
    applyStimulus(0, 0, 0, 1, 0, 0);
    mHealth--;
    checkModel("lastHit", SWin);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkModel("hitInWin", SWin);
    ticks(HoldFrames - 1);
    checkModel("win119", SWin);
    ticks(1);
    mLevel++;
    checkModel("winDone", SClear);
    checkOutput("winDone.clearStart", 32'(clearStart), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("winDone.clearStartOnce", 32'(clearStart), 32'd0);

    tot = $urandom_range(2, 5);
    loadAndServe(tot);
    ticks(ServeFrames);
    checkModel("lvl1Play", SPlay);
    applyStimulus(0, 0, 0, 0, 1, 0);
    mLives--;
    checkModel("lost2to1", SServe);
    ticks(ServeFrames);
    for (int i = 0; i < tot - 1; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 0);
      mHealth--;
      checkModel("hitToOne", SPlay);
    end
    applyStimulus(0, 0, 0, 1, 1, 0);
    mHealth--;
    checkModel("hitAndLost", SWin);
    ticks(HoldFrames);
    mLevel++;
    checkModel("lvl2Clear", SClear);

    loadAndServe(0);
    ticks(HoldFrames - 1);
    checkModel("emptyWin119", SWin);
    ticks(1);
    mLevel++;
    checkModel("lvl3Clear", SClear);

    tot = $urandom_range(2, 6);
    loadAndServe(tot);
    ticks(ServeFrames);
    applyStimulus(0, 0, 0, 1, 0, 0);
    mHealth--;
    checkModel("lvl3Hit", SPlay);
    applyStimulus(0, 0, 0, 0, 1, 0);
    mLives--;
    checkModel("lostLast", SLose);
    applyStimulus(1, 1, 0, 1, 0, 0);
    checkModel("ignoredInLose", SLose);
    ticks(HoldFrames - 1);
    checkModel("lose119", SLose);
    ticks(1);
    checkModel("loseDone", SIdle);

    applyStimulus(1, 0, 0, 0, 0, 0);
    mLives = StartLives; mLevel = 0;
    checkModel("restart", SClear);
    tot = $urandom_range(2, 6);
    loadAndServe(tot);
    ticks(ServeFrames);
    for (int k = 0; k < StartLives; k++) begin
      applyStimulus(0, 0, 0, 0, 1, 0);
      mLives--;
      if (mLives > 0) begin
        checkModel("lostLoop", SServe);
        ticks(ServeFrames);
        checkModel("lostLoopServe", SPlay);
      end else begin
        checkModel("lostLoopEnd", SLose);
      end
    end
    ticks(HoldFrames);
    checkModel("loseDone2", SIdle);

    applyStimulus(1, 0, 0, 0, 0, 0);
    mLives = StartLives; mLevel = 0;
    tot = $urandom_range(2, 6);
    loadAndServe(tot);
    ticks(ServeFrames);
    checkModel("preReset", SPlay);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    mHealth = 0; mLives = StartLives; mLevel = 0;
    checkModel("asyncReset", SIdle);
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkModel("clearDoneInIdle", SIdle);
    checkOutput("clearDoneInIdle.clearStart", 32'(clearStart), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
